melody_sequencer: RTL

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_pkg.sv | 22 ++
 rtl/note_lut.sv | 37 +++
 rtl/melody_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: FSM state encoding,
// special note codes and the datapath widths used across the block.
package melody_pkg;

    localparam int FREQ_W   = 28;  // half-period and duration width
    localparam int ROM_DW   = 16;  // note ROM word width
    localparam int NOTE_W   = 8;   // note code field width
    localparam int DUR_W    = 4;   // duration code field width
    localparam int NOTE_MAX = 48;  // highest pitched code (B6)

    localparam logic [NOTE_W-1:0] NOTE_REST = 8'd0;
    localparam logic [NOTE_W-1:0] NOTE_END  = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_NOTE   = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

endpackage

// File: rtl/note_lut.sv
// Note code to half-period lookup. Codes 1..48 run chromatically from C3
// to B6; every other code returns 0 and is reported as not pitched.
// The table is built at elaboration, so only constants reach the netlist.
module note_lut
    import melody_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic [NOTE_W-1:0] note_code_i,
    output logic [FREQ_W-1:0] half_period_o,
    output logic              pitched_o
);

    // Equal temperament around A4 = 440 Hz (code 22), rounded to nearest cycle.
    function automatic logic [FREQ_W-1:0] calc_half_period(input int code);
        real freq_hz;
        real half_cycles;
        freq_hz     = 440.0 * (2.0 ** ((real'(code) - 22.0) / 12.0));
        half_cycles = real'(CLK_HZ) / (2.0 * freq_hz);
        return FREQ_W'($rtoi(half_cycles + 0.5));
    endfunction

    logic [FREQ_W-1:0] table_w [64];

    for (genvar g = 0; g < 64; g++) begin : g_table
        localparam logic [FREQ_W-1:0] HALF =
            (g >= 1 && g <= NOTE_MAX) ? calc_half_period(g) : '0;
        assign table_w[g] = HALF;
    end

    // Rests and unmapped codes are silent with a zero half-period.
    always_comb begin
        pitched_o     = (note_code_i != NOTE_REST) && (note_code_i <= NOTE_W'(NOTE_MAX));
        half_period_o = pitched_o ? table_w[note_code_i[5:0]] : '0;
    end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a note ROM, drives the external clock divider
// (Freq_out/Tone_en) and note timer (Temp_out/Disparo), and inserts a
// fixed silent gap after each note. Ends at the end marker or at the last
// ROM address, optionally looping back to the start.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TEMPO_BPM  = 120,
    parameter int unsigned GAP_CYCLES = 500_000,
    parameter int unsigned ROM_AW     = 7,
    parameter bit          LOOP       = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Play,
    input  logic              Stop,
    output logic [ROM_AW-1:0] Rom_addr,
    input  logic [ROM_DW-1:0] Rom_data,
    output logic [FREQ_W-1:0] Freq_out,
    output logic              Tone_en,
    output logic [FREQ_W-1:0] Temp_out,
    output logic              Disparo,
    input  logic              Duracao,
    output logic              Busy,
    output logic              Done
);

    // One sixteenth note in clock cycles; 64-bit math keeps CLK_HZ*60 from overflowing.
    localparam logic [63:0] SIXTEENTH_64 =
        (64'(CLK_HZ) * 64'd60) / (64'(TEMPO_BPM) * 64'd4);
    localparam logic [FREQ_W-1:0] SIXTEENTH = SIXTEENTH_64[FREQ_W-1:0];

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

    state_e            state_q,    state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [FREQ_W-1:0] freq_q,     freq_d;
    logic [FREQ_W-1:0] temp_q,     temp_d;
    logic              tone_q,     tone_d;
    logic              disparo_q,  disparo_d;
    logic              done_q,     done_d;
    logic [GAP_W-1:0]  gap_q,      gap_d;

    logic [FREQ_W-1:0] lut_half;
    logic              lut_pitched;
    logic              song_end;
    logic [NOTE_W-1:0] note_code;
    logic [DUR_W-1:0]  dur_code;
    logic              unused_rom_bits;

    assign note_code       = Rom_data[7:0];
    assign dur_code        = Rom_data[11:8];
    assign unused_rom_bits = ^Rom_data[15:12];

    note_lut #(
        .CLK_HZ(CLK_HZ)
    ) u_note_lut (
        .note_code_i  (note_code),
        .half_period_o(lut_half),
        .pitched_o    (lut_pitched)
    );

    // Next-state and output logic; Stop is applied last so it beats Play and end-of-song.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        freq_d     = freq_q;
        temp_d     = temp_q;
        tone_d     = tone_q;
        disparo_d  = 1'b0;
        done_d     = 1'b0;
        gap_d      = gap_q;
        song_end   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (Play) begin
                    rom_addr_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (note_code == NOTE_END) begin
                    song_end = 1'b1;
                end else begin
                    freq_d    = lut_half;
                    temp_d    = ({{(FREQ_W-DUR_W){1'b0}}, dur_code} + FREQ_W'(1)) * SIXTEENTH;
                    tone_d    = lut_pitched;
                    disparo_d = 1'b1;
                    state_d   = ST_NOTE;
                end
            end
            ST_NOTE: begin
                if (Duracao) begin
                    tone_d  = 1'b0;
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    // The last address ends the song rather than wrapping to 0.
                    if (rom_addr_q == ADDR_LAST) begin
                        song_end = 1'b1;
                    end else begin
                        rom_addr_d = rom_addr_q + ROM_AW'(1);
                        state_d    = ST_FETCH;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (song_end) begin
            if (LOOP) begin
                rom_addr_d = '0;
                state_d    = ST_FETCH;
            end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end

        if (Stop) begin
            state_d    = ST_IDLE;
            rom_addr_d = '0;
            tone_d     = 1'b0;
            disparo_d  = 1'b0;
            done_d     = 1'b0;
            gap_d      = '0;
        end
    end

    // State and output registers; all clear asynchronously so the buzzer drops at once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            freq_q     <= '0;
            temp_q     <= '0;
            tone_q     <= 1'b0;
            disparo_q  <= 1'b0;
            done_q     <= 1'b0;
            gap_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values from always_comb.
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            freq_q     <= freq_d;
            temp_q     <= temp_d;
            tone_q     <= tone_d;
            disparo_q  <= disparo_d;
            done_q     <= done_d;
            gap_q      <= gap_d;
        end
    end

    assign Rom_addr = rom_addr_q;
    assign Freq_out = freq_q;
    assign Temp_out = temp_q;
    assign Tone_en  = tone_q;
    assign Disparo  = disparo_q;
    assign Done     = done_q;
    assign Busy     = (state_q != ST_IDLE);

endmodule
